// File: rtl/apb_cmd_master.sv
// Single-outstanding APB requester: valid/ready commands become SETUP/ACCESS transfers,
// each answered by one rsp_valid pulse; a slave that never raises PREADY is aborted with rsp_err.
module apb_cmd_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   // state  | meaning
   // IDLE   | no transfer in flight; cmd_ready high
   // SETUP  | PSEL high, PENABLE low; always exactly one cycle
   // ACCESS | PSEL and PENABLE high; waiting for PREADY or the timeout

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

   assign cmd_ready = (state_q == ST_IDLE) && PRESET;

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               pwrite_d  = cmd_write;
               paddr_d   = cmd_addr;
               pwdata_d  = cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d  = 1'b1;
            wait_cnt_d = '0;
            state_d    = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               state_d     = ST_IDLE;
            end else if (wait_cnt_q == CNT_LAST) begin
               // slave never answered: drop the bus and report the abort
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESET) begin
         state_q     <= ST_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: transaction-level timeline model plus a register-file slave
// with programmable PREADY delay; directed scenarios first, then randomized commands.
module tb_apb_cmd_master;

   localparam int TO    = 16;
   localparam int NEVER = 100;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      int          d;
      int          gap;
      int          rk;
   } cmd_t;

   typedef struct {
      int          n;
      logic        err;
      logic [31:0] rd;
   } rsp_t;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE;
   logic [31:0] rsp_rdata, PADDR, PWDATA;

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   int edge_n = 0;
   always @(posedge PCLK) edge_n <= edge_n + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_n, act, exp);
      end
   endtask

   cmd_t        cq[$];
   rsp_t        rlog[$];
   int          alog[$];
   logic [31:0] mem [16];

   // transaction model: one command in flight, described by its accept edge and ACCESS length
   logic        busy = 1'b0, preset_drv = 1'b0, gap_loaded = 1'b0;
   int          acc_edge = 0, n_acc = 0, cur_d = 0, cur_rk = -1, gap_cnt = 0, init_rst = 3;
   logic        cur_w = 1'b0, cur_err = 1'b0, last_err = 1'b0;
   logic [31:0] cur_a = '0, cur_wd = '0, last_rd = '0;
   int          n, k;
   logic        e_psel, e_pen, e_rv, e_rdy, nxt_rst, prdy, cv, cw;
   logic [31:0] prd, ca, cwd;

   always @(negedge PCLK) begin
      n = edge_n;
      k = n - acc_edge;
      e_psel = busy && (k <= n_acc);
      e_pen  = busy && (k >= 1) && (k <= n_acc);
      e_rv   = busy && (k == n_acc + 1);
      e_rdy  = preset_drv && !e_psel;
      if (e_rv) begin
         last_err = cur_err;
         last_rd  = (cur_err || cur_w) ? 32'h0 : mem[cur_a[5:2]];
         if (cur_w && !cur_err) mem[cur_a[5:2]] = cur_wd;
      end
      chk("psel",      64'(PSEL),      64'(e_psel));
      chk("penable",   64'(PENABLE),   64'(e_pen));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("cmd_ready", 64'(cmd_ready), 64'(e_rdy));
      chk("pwrite",    64'(PWRITE),    64'(cur_w));
      chk("paddr",     64'(PADDR),     64'(cur_a));
      chk("pwdata",    64'(PWDATA),    64'(cur_wd));
      chk("rsp_err",   64'(rsp_err),   64'(last_err));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(last_rd));
      if (rsp_valid === 1'b1) rlog.push_back('{n, rsp_err, rsp_rdata});
      if (e_rv) busy = 1'b0;

      nxt_rst = 1'b1;
      if (init_rst > 0) begin
         nxt_rst = 1'b0;
         init_rst--;
      end
      prdy = 1'($urandom_range(0, 1));
      prd  = $urandom;
      if (busy && (k >= 1) && (k <= n_acc)) begin
         prdy = (cur_d < TO) && (k - 1 == cur_d);
         if (prdy) prd = mem[PADDR[5:2]];
         if (cur_rk == k) begin
            nxt_rst = 1'b0;
            prdy    = 1'b0;
         end
      end
      if (!nxt_rst) begin
         busy = 1'b0; cur_w = 1'b0; cur_a = '0; cur_wd = '0; last_err = 1'b0; last_rd = '0;
      end

      cv  = 1'b0;
      cw  = 1'($urandom_range(0, 1));
      ca  = $urandom;
      cwd = $urandom;
      if (cq.size() > 0) begin
         if (!gap_loaded) begin
            gap_cnt    = cq[0].gap;
            gap_loaded = 1'b1;
         end
         if (gap_cnt > 0) gap_cnt--;
         else begin
            cv = 1'b1; cw = cq[0].w; ca = cq[0].a; cwd = cq[0].wd;
            if (nxt_rst && !busy) begin
               busy = 1'b1; acc_edge = n + 1;
               cur_w = cq[0].w; cur_a = cq[0].a; cur_wd = cq[0].wd;
               cur_d = cq[0].d; cur_rk = cq[0].rk;
               cur_err = (cur_d >= TO);
               n_acc = cur_err ? TO : cur_d + 1;
               alog.push_back(n + 1);
               void'(cq.pop_front());
               gap_loaded = 1'b0;
            end
         end
      end
      PRESET = nxt_rst; preset_drv = nxt_rst;
      cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_wdata = cwd;
      PREADY = prdy; PRDATA = prd;
   end

   function automatic void add(input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input int d, input int gap, input int rk);
      cq.push_back('{w, a, wd, d, gap, rk});
   endfunction

   task automatic drain(input int budget);
      int i = 0;
      while ((cq.size() > 0 || busy) && i < budget) begin
         @(posedge PCLK);
         i++;
      end
      chk("drain_pending", 64'(cq.size() > 0 || busy), 64'(0));
      repeat (3) @(posedge PCLK);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h11111111;
      add(1'b1, 32'h0,  32'h0000000B, 1,     2, -1);
      add(1'b0, 32'h0,  32'h0,        1,     2, -1);
      add(1'b1, 32'h4,  32'hDEAD0001, NEVER, 2, -1);
      add(1'b0, 32'h4,  32'h0,        0,     2, -1);
      add(1'b0, 32'h8,  32'h0,        1,     0, -1);
      add(1'b0, 32'hC,  32'h0,        1,     0, -1);
      add(1'b0, 32'h10, 32'h0,        1,     0, -1);
      add(1'b1, 32'h14, 32'hCAFE0002, 5,     2,  2);
      add(1'b0, 32'h14, 32'h0,        0,     2, -1);
      drain(1000);

      chk("directed_rsp_count", 64'(rlog.size()), 64'(8));
      chk("directed_acc_count", 64'(alog.size()), 64'(9));
      chk("t1_latency", 64'(rlog[0].n - alog[0]), 64'(3));
      chk("t1_err",     64'(rlog[0].err),         64'(0));
      chk("t1_rdata",   64'(rlog[0].rd),          64'(0));
      chk("t2_rdata",   64'(rlog[1].rd),          64'(32'h0000000B));
      chk("t2_err",     64'(rlog[1].err),         64'(0));
      chk("t3_latency", 64'(rlog[2].n - alog[2]), 64'(17));
      chk("t3_err",     64'(rlog[2].err),         64'(1));
      chk("t3_rdata",   64'(rlog[2].rd),          64'(0));
      chk("t3_next_rdata", 64'(rlog[3].rd),       64'(32'h11111111));
      chk("t4_gap_a",   64'(alog[5] - rlog[4].n), 64'(1));
      chk("t4_gap_b",   64'(alog[6] - rlog[5].n), 64'(1));
      chk("t4_rdata",   64'(rlog[6].rd),          64'(32'h44444444));
      chk("t5_after_reset_rdata", 64'(rlog[7].rd), 64'(32'h55555555));

      for (int i = 0; i < 300; i++) begin
         cmd_t c;
         int   r, na;
         c.w  = 1'($urandom_range(0, 1));
         c.a  = 32'($urandom_range(0, 15)) << 2;
         c.wd = $urandom;
         r    = int'($urandom_range(0, 99));
         if (r < 70)      c.d = int'($urandom_range(0, 4));
         else if (r < 85) c.d = int'($urandom_range(TO - 2, TO));
         else             c.d = NEVER;
         c.gap = int'($urandom_range(0, 2));
         c.rk  = -1;
         if ($urandom_range(0, 19) == 0) begin
            na   = (c.d < TO) ? c.d + 1 : TO;
            c.rk = int'($urandom_range(1, na));
         end
         cq.push_back(c);
      end
      drain(20000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
